// File: rtl/slot_bus_decoder.sv
// ---------------------------------------------------------------------------
// slot_bus_decoder
//
// Registered memory-map and slot-bus decoder for the IIgs core. A CPU access
// (bank/addr/we) is captured on a one-cycle req strobe, decoded into exactly
// one memory or peripheral enable (or none for a floating-bus read), and held
// until the access completes. Accesses to the 1 MHz side are stretched until
// the free-running slow-bus phase counter reaches its last phase.
//
// Handshake: req is accepted only in a cycle where busy=0; a req seen while
// busy=1 is dropped, never queued. busy rises the cycle after the accepting
// edge and stays high through the ready cycle. ready is a one-cycle pulse in
// the final cycle of the access. The enables are valid from the first busy
// cycle through the ready cycle and are 0 whenever the block is idle.
//
// Ports:
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   req            one-cycle access strobe; bank/addr/we sampled with it
//   bank, addr, we CPU bank, address and write flag
//   sltromsel      bit n = 1: slot n is an external card, 0: internal firmware
//   busy, ready    access in progress / one-cycle completion pulse
//   fastram_ce, slowram_ce, rom_ce, introm_ce, ioreg_ce   memory enables
//   device_select  one-hot C0n0-C0nF slot strobe
//   io_select      one-hot Cn00-CnFF slot strobe
//   io_strobe      C800-CFFE access owned by an external card
//   exprom_owner   slot currently owning the C800 expansion-ROM space
//   exprom_valid   owner latch is valid
//   dbg_state      FSM state (0 idle, 1 fast/complete, 2 wait)
//   dbg_we         write flag of the access in progress
// ---------------------------------------------------------------------------
module slot_bus_decoder #(
    parameter int          RAMSIZE     = 20,
    parameter logic [7:0]  ROM_BANK_LO = 8'hFE,
    parameter int          SLOW_DIV    = 14,
    parameter int          NUM_SLOTS   = 8,
    localparam int         SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 req,
    input  logic [7:0]           bank,
    input  logic [15:0]          addr,
    input  logic                 we,
    input  logic [NUM_SLOTS-1:0] sltromsel,
    output logic                 busy,
    output logic                 ready,
    output logic                 fastram_ce,
    output logic                 slowram_ce,
    output logic                 rom_ce,
    output logic                 introm_ce,
    output logic                 ioreg_ce,
    output logic [NUM_SLOTS-1:0] device_select,
    output logic [NUM_SLOTS-1:0] io_select,
    output logic                 io_strobe,
    output logic [SW-1:0]        exprom_owner,
    output logic                 exprom_valid,
    output logic [1:0]           dbg_state,
    output logic                 dbg_we
);

    localparam int             PW       = $clog2(SLOW_DIV);
    localparam logic [PW-1:0]  PH_LAST  = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0]  PH_PRE   = PW'(SLOW_DIV - 2);
    localparam logic [7:0]     RAM_TOP  = 8'(RAMSIZE);

    // S_FAST is the single completion cycle for every access: fast accesses
    // go there directly, slow ones pass through S_WAIT first.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FAST = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          phase_q;
    logic                   busy_q, ready_q, we_q;
    logic                   fastram_q, slowram_q, rom_q, introm_q, ioreg_q, strobe_q;
    logic [NUM_SLOTS-1:0]   dev_q, ios_q;
    logic                   cfff_q, iohit_q;
    logic [SW-1:0]          slot_q;
    logic [SW-1:0]          owner_q;
    logic                   valid_q;

    // Decode of the current bus inputs
    logic                   fastram_d, slowram_d, rom_d, introm_d, ioreg_d, strobe_d;
    logic [7:0]             dev8_d, ios8_d;
    logic                   cfff_d, iohit_d, slow_d, io_win;
    logic [7:0]             sel8;
    logic [2:0]             s3, n3, owner3;

    always_comb begin
        fastram_d = 1'b0;
        slowram_d = 1'b0;
        rom_d     = 1'b0;
        introm_d  = 1'b0;
        ioreg_d   = 1'b0;
        strobe_d  = 1'b0;
        dev8_d    = 8'h00;
        ios8_d    = 8'h00;
        cfff_d    = 1'b0;
        iohit_d   = 1'b0;
        sel8      = 8'(sltromsel);
        s3        = addr[6:4];
        n3        = addr[10:8];
        owner3    = 3'(owner_q);
        io_win    = ((bank == 8'h00) || (bank == 8'h01) ||
                     (bank == 8'hE0) || (bank == 8'hE1)) &&
                    (addr[15:12] == 4'hC);

        if (io_win) begin
            if (addr[11:8] == 4'h0) begin
                // C000-C08F is always on-board; this also covers slot 0.
                if (addr[7:4] <= 4'h8) begin
                    ioreg_d = 1'b1;
                end else if (sel8[s3]) begin
                    dev8_d = 8'h01 << s3;
                end else begin
                    ioreg_d = 1'b1;
                end
            end else if (!addr[11]) begin
                if (sel8[n3]) begin
                    ios8_d  = 8'h01 << n3;
                    iohit_d = 1'b1;
                end else begin
                    introm_d = 1'b1;
                end
            end else if (addr[11:0] == 12'hFFF) begin
                introm_d = 1'b1;
                cfff_d   = 1'b1;
            end else if (valid_q && sel8[owner3]) begin
                strobe_d = 1'b1;
            end else begin
                introm_d = 1'b1;
            end
        end else if (bank >= ROM_BANK_LO) begin
            rom_d = 1'b1;
        end else if ((bank == 8'hE0) || (bank == 8'hE1)) begin
            slowram_d = 1'b1;
        end else if (bank < RAM_TOP) begin
            fastram_d = 1'b1;
        end

        slow_d = slowram_d | (|dev8_d) | (|ios8_d) | strobe_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            fastram_q <= 1'b0;
            slowram_q <= 1'b0;
            rom_q     <= 1'b0;
            introm_q  <= 1'b0;
            ioreg_q   <= 1'b0;
            strobe_q  <= 1'b0;
            dev_q     <= '0;
            ios_q     <= '0;
            cfff_q    <= 1'b0;
            iohit_q   <= 1'b0;
            slot_q    <= '0;
            owner_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        busy_q    <= 1'b1;
                        we_q      <= we;
                        fastram_q <= fastram_d;
                        slowram_q <= slowram_d;
                        rom_q     <= rom_d;
                        introm_q  <= introm_d;
                        ioreg_q   <= ioreg_d;
                        strobe_q  <= strobe_d;
                        dev_q     <= dev8_d[NUM_SLOTS-1:0];
                        ios_q     <= ios8_d[NUM_SLOTS-1:0];
                        cfff_q    <= cfff_d;
                        iohit_q   <= iohit_d;
                        slot_q    <= n3[SW-1:0];
                        // A slow access whose next phase is already the last
                        // one completes in that very cycle.
                        if (!slow_d || (phase_q == PH_PRE)) begin
                            state_q <= S_FAST;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (phase_q == PH_PRE) begin
                        state_q <= S_FAST;
                        ready_q <= 1'b1;
                    end
                end

                S_FAST: begin
                    // Completion edge: commit the C800 ownership change.
                    if (iohit_q) begin
                        owner_q <= slot_q;
                        valid_q <= 1'b1;
                    end else if (cfff_q) begin
                        valid_q <= 1'b0;
                    end
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b0;
                    fastram_q <= 1'b0;
                    slowram_q <= 1'b0;
                    rom_q     <= 1'b0;
                    introm_q  <= 1'b0;
                    ioreg_q   <= 1'b0;
                    strobe_q  <= 1'b0;
                    dev_q     <= '0;
                    ios_q     <= '0;
                    cfff_q    <= 1'b0;
                    iohit_q   <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign ready         = ready_q;
    assign fastram_ce    = fastram_q;
    assign slowram_ce    = slowram_q;
    assign rom_ce        = rom_q;
    assign introm_ce     = introm_q;
    assign ioreg_ce      = ioreg_q;
    assign io_strobe     = strobe_q;
    assign device_select = dev_q;
    assign io_select     = ios_q;
    assign exprom_owner  = owner_q;
    assign exprom_valid  = valid_q;
    assign dbg_state     = state_q;
    assign dbg_we        = we_q;

endmodule
